// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider (signed/unsigned), one quotient bit
// per cycle, with registered quotient/remainder for the HI/LO write-back path.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;      // dividend magnitude, shifts into the quotient
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic [WIDTH-1:0] prem;     // partial remainder
  logic             q_neg;
  logic             r_neg;
  logic             dz;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;

  // Magnitude of a two's-complement value when signed mode is selected.
  // The most negative value maps onto itself, which is the correct unsigned
  // magnitude and gives the overflow case its result without special handling.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic en);
    return (en && v[WIDTH-1]) ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  // Conditional two's-complement negation used to restore result signs.
  function automatic logic [WIDTH-1:0] neg_if(input logic signed [WIDTH-1:0] v,
                                              input logic en);
    return en ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  assign busy_o = (state != IDLE);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_i) state_next = (src2_i == '0) ? FIX : CALC;
      CALC: if (cnt == CW'(1)) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Trial subtraction: shifted partial remainder needs one extra bit, and the
  // top bit of the difference tells whether the divisor fit.
  always_comb begin
    rem_sh = {prem, dvd[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs};
  end

  // Operand capture, iteration and result registration.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt         <= '0;
      done_o      <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      div_zero_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            q_neg <= signed_i & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
            r_neg <= signed_i & src1_i[WIDTH-1];
            dvs   <= mag(src2_i, signed_i);
            prem  <= '0;
            cnt   <= CW'(WIDTH);
            if (src2_i == '0) begin
              // Keep the raw dividend: it is returned as the remainder.
              dz  <= 1'b1;
              dvd <= src1_i;
            end else begin
              dz  <= 1'b0;
              dvd <= mag(src1_i, signed_i);
            end
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (!trial[WIDTH]) prem <= trial[WIDTH-1:0];
          else               prem <= rem_sh[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
        end
        FIX: begin
          done_o     <= 1'b1;
          div_zero_o <= dz;
          if (dz) begin
            quotient_o  <= '1;
            remainder_o <= dvd;
          end else begin
            quotient_o  <= neg_if(dvd, q_neg);
            remainder_o <= neg_if(prem, r_neg);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors for div_unit with a queue-based scoreboard.
module tb_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sgn;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic         dzero;

  div_unit #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .signed_i   (sgn),
    .src1_i     (a),
    .src2_i     (b),
    .busy_o     (busy),
    .done_o     (done),
    .quotient_o (quo),
    .remainder_o(rem),
    .div_zero_o (dzero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           edge_at;
    string        name;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int dones = 0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Monitor: pop and compare whenever the DUT reports a result.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && done === 1'b1) begin
      dones++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_q"},    quo,       e.q);
        check({e.name, "_r"},    rem,       e.r);
        check({e.name, "_dz"},   W'(dzero), W'(e.dz));
        check({e.name, "_lat"},  W'(cyc),   W'(e.edge_at));
        check({e.name, "_busy"}, W'(busy),  0);
      end
    end
  end

  // Issue one request at the current negedge; start is sampled at the next edge.
  task automatic op(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                    input logic edz, input int lat, input bit push = 1'b1);
    exp_t e;
    a = x;
    b = y;
    sgn = s;
    start = 1'b1;
    if (push) begin
      e.q = eq;
      e.r = er;
      e.dz = edz;
      e.edge_at = cyc + 1 + lat;
      e.name = nm;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_timeout"}, W'(n >= 60), 0);
  endtask

  task automatic run(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                     input logic edz, input int lat);
    op(nm, x, y, s, eq, er, edz, lat);
    wait_done(nm);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bit busy_ok;
    int d0;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_q",    quo, 0);
    check("rst_r",    rem, 0);
    check("rst_dz",   W'(dzero), 0);
    check("rst_done", W'(done), 0);
    check("rst_busy", W'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // 100 / 7 with the busy window watched cycle by cycle
    op("u100_7", 100, 7, 1'b0, 14, 2, 1'b0, 33);
    busy_ok = 1'b1;
    repeat (33) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
    end
    check("busy_window", W'(busy_ok), 1);
    wait_done("u100_7");
    @(negedge clk);

    run("s_m7_2",  32'hFFFFFFF9, 32'h2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33);
    run("u_m7_2",  32'hFFFFFFF9, 32'h2,        1'b0, 32'h7FFFFFFC, 32'h1,        1'b0, 33);
    run("dz_5_0",  32'h5,        32'h0,        1'b0, 32'hFFFFFFFF, 32'h5,        1'b1, 1);
    run("u20_3",   32'd20,       32'd3,        1'b0, 32'd6,        32'd2,        1'b0, 33);
    run("ovf",     32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0,        1'b0, 33);
    run("s7_m2",   32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'h1,        1'b0, 33);
    run("dz_s",    32'hFFFFFFF9, 32'h0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1);
    run("u_max_1", 32'hFFFFFFFF, 32'h1,        1'b0, 32'hFFFFFFFF, 32'h0,        1'b0, 33);
    run("u0_5",    32'h0,        32'h5,        1'b0, 32'h0,        32'h0,        1'b0, 33);

    // Start while busy is ignored; start in the done cycle is accepted
    op("hs_first", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 33);
    repeat (9) @(negedge clk);
    a = 32'd9; b = 32'd3; sgn = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_during_ignored", W'(busy), 1);
    wait_done("hs_first");
    op("b2b", 32'd50, 32'hFFFFFFF9, 1'b1, 32'hFFFFFFF9, 32'h1, 1'b0, 33);
    wait_done("b2b");
    @(negedge clk);

    // Reset in the middle of an operation
    op("aborted", 32'd77, 32'd5, 1'b0, 0, 0, 1'b0, 33, 1'b0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_q",    quo, 0);
    check("abort_r",    rem, 0);
    check("abort_dz",   W'(dzero), 0);
    check("abort_done", W'(done), 0);
    check("abort_busy", W'(busy), 0);
    rst = 1'b0;
    d0 = dones;
    repeat (40) @(negedge clk);
    check("no_done_after_abort", W'(dones), W'(d0));
    run("post_rst", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33);

    // Reset and start together: reset wins
    rst = 1'b1; a = 32'd9; b = 32'd3; sgn = 1'b0; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", W'(busy), 0);
    d0 = dones;
    repeat (40) @(negedge clk);
    check("rst_start_no_done", W'(dones), W'(d0));
    check("sb_empty", W'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle iterative integer divider for the MIPS datapath, the inverse companion of the single-cycle multiply already in the ALU. It accepts a dividend/divisor pair under a start/busy/done handshake and computes quotient and remainder by restoring division, one bit per cycle. It supports signed and unsigned division, and registers its results for the HI/LO write-back path.

## Interface

- WIDTH, 32, operand/result width in bits (counter sized to hold WIDTH)
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  request; sampled only when busy_o is low
- signed_i  in  1  1 = two's-complement division, 0 = unsigned; sampled with start_i
- src1_i  in  WIDTH  dividend; sampled with start_i
- src2_i  in  WIDTH  divisor; sampled with start_i
- busy_o  out  1  high while an operation is in flight (state != IDLE)
- done_o  out  1  one-cycle pulse: results valid
- quotient_o  out  WIDTH  registered quotient, held until the next done_o
- remainder_o  out  WIDTH  registered remainder, held until the next done_o
- div_zero_o  out  1  registered; 1 if the last completed operation had divisor 0

## Operation

- States: IDLE, CALC, FIX.
- IDLE with start_i=1:
  - Latch the sign flags: quotient negative = signed_i & (src1 MSB ^ src2 MSB); remainder negative = signed_i & src1 MSB.
  - Latch the operand magnitudes: absolute values if signed_i, raw values otherwise.
  - Clear the partial remainder, load the counter with WIDTH, and go to CALC.
  - If src2_i == 0, go directly to FIX instead, with the divide-by-zero flag set.
- CALC, each cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor in WIDTH+1 bits. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter. When the counter reaches 1 on this edge, go to FIX.
- FIX, one cycle:
  - Negate the quotient and/or remainder per the latched flags.
  - Register quotient_o, remainder_o and div_zero_o, pulse done_o, and go to IDLE.
- Divide by zero: quotient_o = all ones, remainder_o = src1_i unmodified, div_zero_o = 1. This applies regardless of signed_i.
- Signed overflow (most negative / -1): quotient_o = 0x80000000 (WIDTH=32), remainder_o = 0, div_zero_o = 0. Magnitude arithmetic yields this with no special case.
- Remainder sign follows the dividend. Quotient truncates toward zero.
- start_i while busy_o=1 is ignored. The operation in flight is unaffected and the request is not queued.
- Outputs other than done_o hold their last values while IDLE and during CALC.

## Timing

- Reset values: state IDLE, busy_o 0, done_o 0, quotient_o 0, remainder_o 0, div_zero_o 0, counter 0.
- Normal case, with start sampled at edge E0:
  - busy_o is high after E0.
  - CALC occupies edges E1..E(WIDTH).
  - FIX at edge E(WIDTH+1) sets done_o=1 and drops busy_o.
  - Latency is WIDTH+1 edges (33 for WIDTH=32).
- Divide by zero: done_o is set at edge E1, a latency of 1 edge.
- done_o is high for exactly one cycle. It deasserts on the next edge unless another FIX occurs.
- Back-to-back: start_i asserted in the done_o cycle is accepted at the following edge, since busy_o is already low.
- Reset mid-operation: at the reset edge, state returns to IDLE and all outputs clear. No done_o is produced for the aborted operation.
- Reset and start_i in the same cycle: reset wins, and the request is dropped.

## Test plan

- Unsigned 100 / 7: start with signed_i=0 -> done_o exactly 33 edges later, quotient_o=14, remainder_o=2, div_zero_o=0, busy_o high for cycles 1..33.
- Signed -7 / 2 (0xFFFFFFF9 / 0x2): signed_i=1 -> quotient_o=0xFFFFFFFD, remainder_o=0xFFFFFFFF. The same operands with signed_i=0 -> quotient_o=0x7FFFFFFC, remainder_o=1.
- Divide by zero, 5 / 0: -> done_o 1 edge after start, quotient_o=0xFFFFFFFF, remainder_o=5, div_zero_o=1. The next valid divide clears div_zero_o.
- Signed overflow 0x80000000 / 0xFFFFFFFF: -> quotient_o=0x80000000, remainder_o=0, div_zero_o=0, latency 33.
- Handshake: a second start_i with different operands at cycle 10 of an operation -> ignored, first result unchanged. A start_i in the done_o cycle -> accepted, second done_o exactly 33 edges later.
- Reset at cycle 15 of an operation -> all outputs 0 at the next edge, busy_o 0, no done_o for at least 40 cycles without a new start.
